// File: rtl/spi_slave_debug_if.sv
// ---------------------------------------------------------------------------
// spi_slave_debug_if
// Bundles the SPI pins and the decode-stage request/response word of the
// debug SPI slave.
//   i_sclk, i_cs_n, i_mosi : SPI pins driven by the host (asynchronous)
//   o_miso                 : SPI serial data back to the host
//   i_data                 : response word from the decode stage
//   o_data, o_valid        : last complete request word and its update strobe
//   o_in_frame             : slave is inside a frame (state != IDLE)
// modport slave  : view of the SPI slave itself
// modport master : view of the host side / environment
// ---------------------------------------------------------------------------
interface spi_slave_debug_if #(
  parameter int NB_BITS = 32
);
  logic               i_sclk;
  logic               i_cs_n;
  logic               i_mosi;
  logic               o_miso;
  logic [NB_BITS-1:0] i_data;
  logic [NB_BITS-1:0] o_data;
  logic               o_valid;
  logic               o_in_frame;

  modport slave (
    input  i_sclk, i_cs_n, i_mosi, i_data,
    output o_miso, o_data, o_valid, o_in_frame
  );

  modport master (
    output i_sclk, i_cs_n, i_mosi, i_data,
    input  o_miso, o_data, o_valid, o_in_frame
  );
endinterface

// File: rtl/spi_slave_debug.sv
// ---------------------------------------------------------------------------
// spi_slave_debug
// SPI mode-0 slave for the debug unit, NB_BITS-bit frames, MSB first.
// SCLK/CS/MOSI are oversampled in the clk domain. The request shifted in
// during a frame is published on o_data at frame end; the response word
// i_data captured at CS fall is shifted out on MISO during that frame.
// Ports:
//   clk  : system clock (only clock of the block)
//   rst  : asynchronous reset, active high
//   bus  : spi_slave_debug_if.slave (SPI pins, request/response words,
//          o_valid strobe, o_in_frame status)
// ---------------------------------------------------------------------------
module spi_slave_debug #(
  parameter int NB_BITS = 32,
  parameter int NB_SYNC = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_slave_debug_if.slave    bus
);

  localparam int NB_CNT = $clog2(NB_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_WAIT_CS = 2'd2
  } state_t;

  // Synchroniser chains plus edge-detect history
  logic [NB_SYNC-1:0] r_sclk_sync;
  logic [NB_SYNC-1:0] r_cs_sync;
  logic [NB_SYNC-1:0] r_mosi_sync;
  logic               r_sclk_prev;
  logic               r_cs_prev;
  // r_live: at least one real sample has entered the chains since reset.
  // r_armed: CS has been seen high since reset, so a CS fall is genuine.
  logic               r_live;
  logic               r_armed;

  state_t             r_state;
  logic [NB_CNT-1:0]  r_cnt;
  logic [NB_BITS-1:0] r_rx_sr;
  logic [NB_BITS-1:0] r_tx_sr;
  logic [NB_BITS-1:0] r_data;
  logic               r_valid;
  logic               r_miso;
  logic               r_in_frame;

  logic               w_sclk_s;
  logic               w_cs_s;
  logic               w_mosi_s;
  logic               w_rise;
  logic               w_fall;
  logic               w_cs_fall;

  state_t             w_state_nxt;
  logic [NB_CNT-1:0]  w_cnt_nxt;
  logic [NB_BITS-1:0] w_rx_nxt;
  logic [NB_BITS-1:0] w_tx_nxt;
  logic [NB_BITS-1:0] w_data_nxt;
  logic               w_valid_nxt;
  logic               w_miso_nxt;
  logic               w_in_frame_nxt;

  assign w_sclk_s  = r_sclk_sync[NB_SYNC-1];
  assign w_cs_s    = r_cs_sync[NB_SYNC-1];
  assign w_mosi_s  = r_mosi_sync[NB_SYNC-1];
  assign w_rise    = w_sclk_s & ~r_sclk_prev;
  assign w_fall    = ~w_sclk_s & r_sclk_prev;
  assign w_cs_fall = ~w_cs_s & r_cs_prev;

  // Input synchronisers, edge history and the CS arming flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
      r_live      <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[NB_SYNC-2:0], bus.i_sclk};
      r_cs_sync   <= {r_cs_sync[NB_SYNC-2:0], bus.i_cs_n};
      r_mosi_sync <= {r_mosi_sync[NB_SYNC-2:0], bus.i_mosi};
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
      r_live      <= 1'b1;
      // The reset value of the CS chain is not a real observation, so only
      // samples taken after the first post-reset clock may arm the slave.
      if (r_live && r_cs_sync[0]) begin
        r_armed <= 1'b1;
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, shift registers, request word and output strobes
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_rx_nxt       = r_rx_sr;
    w_tx_nxt       = r_tx_sr;
    w_data_nxt     = r_data;
    w_valid_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall && r_armed) begin
          w_state_nxt = ST_SHIFT;
          w_tx_nxt    = bus.i_data;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // The final rise wins over a simultaneous CS deassertion.
        if (w_rise && (r_cnt == NB_CNT'(NB_BITS - 1))) begin
          w_rx_nxt    = {r_rx_sr[NB_BITS-2:0], w_mosi_s};
          w_data_nxt  = {r_rx_sr[NB_BITS-2:0], w_mosi_s};
          w_cnt_nxt   = r_cnt + NB_CNT'(1);
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_WAIT_CS;
        end else if (w_cs_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_rise) begin
          w_rx_nxt  = {r_rx_sr[NB_BITS-2:0], w_mosi_s};
          w_cnt_nxt = r_cnt + NB_CNT'(1);
        end else if (w_fall) begin
          w_tx_nxt = {r_tx_sr[NB_BITS-2:0], 1'b0};
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_WAIT_CS: begin
        if (w_cs_s) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_CS;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // MISO follows the shifter only while a frame is being shifted.
    if (r_state == ST_SHIFT) begin
      w_miso_nxt = r_tx_sr[NB_BITS-1];
    end else begin
      w_miso_nxt = 1'b0;
    end
    w_in_frame_nxt = (w_state_nxt != ST_IDLE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_rx_sr    <= '0;
      r_tx_sr    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_miso     <= 1'b0;
      r_in_frame <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_rx_sr    <= w_rx_nxt;
      r_tx_sr    <= w_tx_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_miso     <= w_miso_nxt;
      r_in_frame <= w_in_frame_nxt;
    end
  end

  assign bus.o_data     = r_data;
  assign bus.o_valid    = r_valid;
  assign bus.o_miso     = r_miso;
  assign bus.o_in_frame = r_in_frame;

endmodule

// File: tb/tb_spi_slave_debug.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_debug
// Scoreboard bench for spi_slave_debug. The host tasks push the expected
// request word and expected MISO word of each complete frame; independent
// monitors pop them when the DUT pulses o_valid and when CS rises.
// ---------------------------------------------------------------------------
module tb_spi_slave_debug;

  logic        clk;
  logic        rst;
  logic        follow;
  logic [31:0] tb_idata;

  int n_checks;
  int n_fail;

  logic [31:0] q_req[$];
  logic [31:0] q_rsp[$];

  spi_slave_debug_if #(.NB_BITS(32)) bus ();

  spi_slave_debug #(.NB_BITS(32), .NB_SYNC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // In follow mode the bench's decode model answers each request with its
  // bitwise complement.
  assign bus.i_data = follow ? ~bus.o_data : tb_idata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h expected=%08h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Request scoreboard: o_valid pops one expected request word.
  always @(negedge clk) begin
    if (!rst && bus.o_valid) begin
      if (q_req.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL req_unexpected got=%08h expected=no_pulse", bus.o_data);
      end else begin
        check("req_word", bus.o_data, q_req.pop_front());
      end
    end
  end

  // MISO scoreboard: capture at SCLK rise, compare at CS rise.
  int          m_cnt;
  logic [31:0] m_word;
  logic        m_tail;
  always @(posedge bus.i_sclk or posedge bus.i_cs_n or posedge rst) begin
    if (rst) begin
      m_cnt  = 0;
      m_word = 32'h0;
      m_tail = 1'b0;
    end else if (bus.i_cs_n) begin
      if (m_cnt >= 32) begin
        if (q_rsp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected got=%08h expected=none", m_word);
        end else begin
          check("rsp_word", m_word, q_rsp.pop_front());
        end
        if (m_cnt > 32) begin
          check("miso_tail_zero", {31'h0, m_tail}, 32'h0);
        end
      end
      m_cnt  = 0;
      m_word = 32'h0;
      m_tail = 1'b0;
    end else begin
      if (m_cnt < 32) begin
        m_word = {m_word[30:0], bus.o_miso};
      end else begin
        m_tail = m_tail | bus.o_miso;
      end
      m_cnt++;
    end
  end

  // One host frame at f_clk/8; pushes expectations only for full frames.
  task automatic frame(input logic [31:0] w, input int nbits, input logic [31:0] rsp,
                       input bit mid_chk, input logic [31:0] mid_exp);
    if (nbits >= 32) begin
      q_req.push_back(w);
      q_rsp.push_back(rsp);
    end
    bus.i_cs_n = 1'b0;
    bus.i_mosi = w[31];
    wait_clk(6);
    for (int i = 0; i < nbits; i++) begin
      bus.i_sclk = 1'b1;
      wait_clk(4);
      bus.i_sclk = 1'b0;
      if (i + 1 < 32) begin
        bus.i_mosi = w[30-i];
      end else begin
        bus.i_mosi = 1'b1;
      end
      if (mid_chk && i == 16) begin
        check("odata_hold_mid", bus.o_data, mid_exp);
      end
      wait_clk(4);
    end
    bus.i_cs_n = 1'b1;
    wait_clk(6);
  endtask

  localparam int N_RAND = 200;

  initial begin
    logic [31:0] w;
    logic [31:0] r;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    follow      = 1'b0;
    tb_idata    = 32'h0;
    bus.i_cs_n  = 1'b1;
    bus.i_sclk  = 1'b0;
    bus.i_mosi  = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);
    check("rst_o_data", bus.o_data, 32'h0);
    check("rst_o_valid", {31'h0, bus.o_valid}, 32'h0);
    check("rst_o_miso", {31'h0, bus.o_miso}, 32'h0);
    check("rst_o_in_frame", {31'h0, bus.o_in_frame}, 32'h0);
    wait_clk(4);

    // Single frame
    tb_idata = 32'h12345678;
    frame(32'h00A30000, 32, 32'h12345678, 1'b0, 32'h0);
    check("t1_o_data", bus.o_data, 32'h00A30000);

    // Back-to-back with decode model in the loop
    follow = 1'b1;
    frame(32'h00810000, 32, 32'hFF5CFFFF, 1'b1, 32'h00A30000);
    check("t2a_o_data", bus.o_data, 32'h00810000);
    frame(32'h00000000, 32, 32'hFF7EFFFF, 1'b1, 32'h00810000);
    check("t2b_o_data", bus.o_data, 32'h00000000);
    follow = 1'b0;

    // Abort after 17 bits
    tb_idata = 32'h0BADF00D;
    frame(32'hFFFFFFFF, 17, 32'h0, 1'b0, 32'h0);
    check("t3_abort_hold", bus.o_data, 32'h00000000);
    tb_idata = 32'hCAFEF00D;
    frame(32'h00400000, 32, 32'hCAFEF00D, 1'b0, 32'h0);
    check("t3_o_data", bus.o_data, 32'h00400000);

    // Overlong frame
    tb_idata = 32'h5A5AA5A5;
    frame(32'hDEADBEEF, 40, 32'h5A5AA5A5, 1'b0, 32'h0);
    check("t4_o_data", bus.o_data, 32'hDEADBEEF);

    // Reset at bit 10, released with CS still low
    tb_idata   = 32'h77777777;
    w          = 32'hA5A5A5A5;
    bus.i_cs_n = 1'b0;
    bus.i_mosi = w[31];
    wait_clk(6);
    for (int i = 0; i < 10; i++) begin
      bus.i_sclk = 1'b1;
      wait_clk(4);
      bus.i_sclk = 1'b0;
      bus.i_mosi = w[30-i];
      wait_clk(4);
    end
    rst = 1'b1;
    wait_clk(2);
    check("t5_rst_o_data", bus.o_data, 32'h0);
    check("t5_rst_o_miso", {31'h0, bus.o_miso}, 32'h0);
    check("t5_rst_o_in_frame", {31'h0, bus.o_in_frame}, 32'h0);
    rst = 1'b0;
    for (int i = 10; i < 32; i++) begin
      bus.i_sclk = 1'b1;
      wait_clk(4);
      bus.i_sclk = 1'b0;
      if (i < 31) begin
        bus.i_mosi = w[30-i];
      end else begin
        bus.i_mosi = 1'b0;
      end
      wait_clk(4);
      check("t5_quiet", {bus.o_data[28:0], bus.o_valid, bus.o_miso, bus.o_in_frame}, 32'h0);
    end
    check("t5_quiet_o_data", bus.o_data, 32'h0);
    bus.i_cs_n = 1'b1;
    wait_clk(6);
    tb_idata = 32'h55667788;
    frame(32'h11223344, 32, 32'h55667788, 1'b0, 32'h0);
    check("t5_fresh_o_data", bus.o_data, 32'h11223344);

    // Random traffic at f_clk/8
    for (int n = 0; n < N_RAND; n++) begin
      w        = $urandom;
      r        = $urandom;
      tb_idata = r;
      frame(w, 32, r, 1'b0, 32'h0);
    end

    wait_clk(10);
    check("req_queue_drained", q_req.size(), 32'h0);
    check("rsp_queue_drained", q_rsp.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
